seg7_scan_capture: RTL and testbench

Receiving end of the multiplexed 8-digit seven-segment display interface driven by top (AN/A2G). It samples the scanned anode/segment lines, waits for each pattern to settle, and decodes each glyph back to a hex nibble. It assembles a 32-bit word and pulses a flag once all 8 digit positions have been captured. It is used on-board as a display loop-back monitor and in benches to check displayed values without decoding waveforms by eye.

---
 rtl/seg7_scan_capture.sv | 171 +++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// Seven-segment scan monitor: samples the multiplexed anode/segment lines, waits for each
// pattern to settle, decodes glyphs back to nibbles and publishes a word once all 8 digits are seen.
module seg7_scan_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [7:0]  AN,
  input  logic [6:0]  A2G,
  output logic [31:0] value,
  output logic [7:0]  blank_mask,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        an_err
);

  // state | meaning
  // WAIT  | pattern not yet stable long enough; evaluate once cnt reaches SETTLE
  // HELD  | current pattern already evaluated; wait for it to change
  typedef enum logic {WAIT_S = 1'b0, HELD_S = 1'b1} state_t;

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  logic [14:0] sync1_q, sync2_q, prev_q;
  logic [7:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic        eval_en, changed;

  logic [31:0] shadow_q, shadow_d, value_q, value_d;
  logic [7:0]  sblank_q, sblank_d, blank_q, blank_d, seen_q, seen_d;
  logic        fv_q, fv_d, seg_err_q, seg_err_d, an_err_q, an_err_d;

  logic [7:0]  an_low;
  logic [6:0]  seg;
  logic        an_onehot;
  logic [4:0]  glyph;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h7E: decode = {1'b1, 4'h0};
      7'h30: decode = {1'b1, 4'h1};
      7'h6D: decode = {1'b1, 4'h2};
      7'h79: decode = {1'b1, 4'h3};
      7'h33: decode = {1'b1, 4'h4};
      7'h5B: decode = {1'b1, 4'h5};
      7'h5F: decode = {1'b1, 4'h6};
      7'h70: decode = {1'b1, 4'h7};
      7'h7F: decode = {1'b1, 4'h8};
      7'h7B: decode = {1'b1, 4'h9};
      7'h77: decode = {1'b1, 4'hA};
      7'h1F: decode = {1'b1, 4'hB};
      7'h4E: decode = {1'b1, 4'hC};
      7'h3D: decode = {1'b1, 4'hD};
      7'h4F: decode = {1'b1, 4'hE};
      7'h47: decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  assign changed   = (sync2_q != prev_q);
  assign an_low    = ~sync2_q[14:7];
  assign seg       = SEG_ACTIVE_LOW ? ~sync2_q[6:0] : sync2_q[6:0];
  assign an_onehot = (an_low != 8'h00) && ((an_low & (an_low - 8'h01)) == 8'h00);
  assign glyph     = decode(seg);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      state_q <= WAIT_S;
    end else begin
      sync1_q <= {AN, A2G};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (changed)
      cnt_d = 8'h00;
    else if (cnt_q < SETTLE)
      cnt_d = cnt_q + 8'h01;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_S: if (!changed && cnt_q == SETTLE) state_d = HELD_S;
      HELD_S: if (changed) state_d = WAIT_S;
      default: state_d = WAIT_S;
    endcase
  end

  always_comb begin
    eval_en = (state_q == WAIT_S) && !changed && (cnt_q == SETTLE);
  end

  always_comb begin
    shadow_d  = shadow_q;
    sblank_d  = sblank_q;
    seen_d    = seen_q;
    value_d   = value_q;
    blank_d   = blank_q;
    fv_d      = 1'b0;
    seg_err_d = 1'b0;
    an_err_d  = 1'b0;
    if (seen_q == 8'hFF) begin
      value_d = shadow_q;
      blank_d = sblank_q;
      fv_d    = 1'b1;
      seen_d  = 8'h00;
    end
    // an_low == 0 is the inter-digit blanking gap and is ignored
    if (eval_en && an_low != 8'h00) begin
      if (!an_onehot) begin
        an_err_d = 1'b1;
      end else begin
        for (int d = 0; d < 8; d++) begin
          if (an_low[d]) begin
            if (seg == 7'h00) begin
              sblank_d[d]        = 1'b1;
              shadow_d[4*d +: 4] = 4'h0;
              seen_d[d]          = 1'b1;
            end else if (glyph[4]) begin
              sblank_d[d]        = 1'b0;
              shadow_d[4*d +: 4] = glyph[3:0];
              seen_d[d]          = 1'b1;
            end else begin
              seg_err_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      shadow_q  <= '0;
      sblank_q  <= '0;
      seen_q    <= '0;
      value_q   <= '0;
      blank_q   <= '0;
      fv_q      <= 1'b0;
      seg_err_q <= 1'b0;
      an_err_q  <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      sblank_q  <= sblank_d;
      seen_q    <= seen_d;
      value_q   <= value_d;
      blank_q   <= blank_d;
      fv_q      <= fv_d;
      seg_err_q <= seg_err_d;
      an_err_q  <= an_err_d;
    end
  end

  assign value       = value_q;
  assign blank_mask  = blank_q;
  assign frame_valid = fv_q;
  assign seg_err     = seg_err_q;
  assign an_err      = an_err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: scans hex words through the display lines and
// checks decoded frames, blank mask and error pulse counts.
module tb_seg7_scan_capture;

  logic        clk;
  logic        rst_n;
  logic [7:0]  an;
  logic [6:0]  a2g;
  logic [31:0] value;
  logic [7:0]  blank_mask;
  logic        frame_valid, seg_err, an_err;

  int n_vec  = 0;
  int n_miss = 0;
  int fv_cnt = 0, se_cnt = 0, ae_cnt = 0;
  int fv0, se0, ae0;

  // active-low segment codes for hex digits 0..F
  logic [6:0] gl_al [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  seg7_scan_capture dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .AN         (an),
    .A2G        (a2g),
    .value      (value),
    .blank_mask (blank_mask),
    .frame_valid(frame_valid),
    .seg_err    (seg_err),
    .an_err     (an_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (seg_err)     se_cnt++;
    if (an_err)      ae_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_miss++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic show(input logic [7:0] an_v, input logic [6:0] seg_v, input int n);
    an  = an_v;
    a2g = seg_v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [31:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      show(~(8'h01 << i), gl_al[w[4*i +: 4]], 16);
  endtask

  task automatic idle();
    show(8'hFF, 7'h7F, 16);
  endtask

  task automatic snap();
    fv0 = fv_cnt;
    se0 = se_cnt;
    ae0 = ae_cnt;
  endtask

  initial begin
    rst_n = 1'b0;
    an    = 8'hFF;
    a2g   = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", value, 32'h0);
    check("rst_blank", {24'h0, blank_mask}, 32'h0);
    check("rst_pulses", {29'h0, frame_valid, seg_err, an_err}, 32'h0);
    rst_n = 1'b1;
    idle();

    // full scan of 0x12345678
    snap();
    scan(32'h12345678, 0, 7);
    idle();
    check("t1_fv_cnt", fv_cnt - fv0, 1);
    check("t1_value", value, 32'h12345678);
    check("t1_blank", {24'h0, blank_mask}, 32'h0);
    check("t1_err_cnt", (se_cnt - se0) + (ae_cnt - ae0), 0);

    // short non-hex glitch before digit 3 must be ignored
    snap();
    scan(32'h12345678, 0, 2);
    show(8'hF7, 7'h7D, 2);
    scan(32'h12345678, 3, 7);
    idle();
    check("t2_seg_err_cnt", se_cnt - se0, 0);
    check("t2_fv_cnt", fv_cnt - fv0, 1);
    check("t2_value", value, 32'h12345678);

    // digit 5 shows a lone segment f: one seg_err, frame held back
    snap();
    scan(32'h89ABCDEF, 0, 4);
    show(8'hDF, 7'h7D, 16);
    scan(32'h89ABCDEF, 6, 7);
    idle();
    check("t3_seg_err_cnt", se_cnt - se0, 1);
    check("t3_fv_none", fv_cnt - fv0, 0);
    check("t3_value_old", value, 32'h12345678);
    scan(32'h89ABCDEF, 5, 5);
    idle();
    check("t3_fv_cnt", fv_cnt - fv0, 1);
    check("t3_value", value, 32'h89ABCDEF);

    // two anodes low: one an_err, no effect on seen
    snap();
    scan(32'h76543210, 0, 3);
    show(8'hF3, 7'h00, 10);
    idle();
    check("t4_an_err_cnt", ae_cnt - ae0, 1);
    check("t4_fv_none", fv_cnt - fv0, 0);
    scan(32'h76543210, 4, 7);
    idle();
    check("t4_fv_cnt", fv_cnt - fv0, 1);
    check("t4_value", value, 32'h76543210);

    // blank digit 2
    snap();
    scan(32'hFFFFFFFF, 0, 1);
    show(8'hFB, 7'h7F, 16);
    scan(32'hFFFFFFFF, 3, 7);
    idle();
    check("t5_fv_cnt", fv_cnt - fv0, 1);
    check("t5_value", value, 32'hFFFFF0FF);
    check("t5_blank", {24'h0, blank_mask}, 32'h04);

    // reset mid-frame discards the partial capture
    scan(32'h11111111, 0, 3);
    rst_n = 1'b0;
    #3;
    check("t6_rst_value", value, 32'h0);
    check("t6_rst_blank", {24'h0, blank_mask}, 32'h0);
    check("t6_rst_pulses", {29'h0, frame_valid, seg_err, an_err}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    snap();
    scan(32'hDEADBEEF, 4, 7);
    idle();
    check("t6_no_stale_frame", fv_cnt - fv0, 0);
    scan(32'hDEADBEEF, 0, 7);
    idle();
    check("t6_fv_cnt", fv_cnt - fv0, 1);
    check("t6_value", value, 32'hDEADBEEF);
    check("t6_blank", {24'h0, blank_mask}, 32'h0);
    check("t6_err_cnt", (se_cnt - se0) + (ae_cnt - ae0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
